// File: rtl/rc4_stream_ctrl_if.sv
// rc4_stream_ctrl_if
// Byte stream pair around the rc4 stream controller: a plaintext valid/ready
// stream into the controller and a ciphertext valid/ready stream out of it.
//   in_valid / in_ready / in_data    : plaintext stream (master -> slave)
//   out_valid / out_ready / out_data : ciphertext stream (slave -> master)
// The controller uses the slave modport; the traffic source/sink uses master.
interface rc4_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl
// Sequencer and stream front-end for the rc4 keystream core. Owns the core
// reset and clock-enable, loads an 8-byte key from a host-written buffer,
// waits out key scheduling plus the discard, then XORs a byte stream with the
// keystream, advancing the core exactly once per accepted input byte.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   key_we/addr/data: key buffer write port
//   start           : one-cycle pulse, (re)key the core
//   busy/ks_ready/err: status (RESET/LOAD/WAIT, CRYPTO, ERROR)
//   byte_cnt        : bytes accepted since last start (wraps)
//   core_rst/core_ce/core_key : drive the core (core_ce feeds its clock gate)
//   core_ready/core_k         : from the core
//   strm            : plaintext in / ciphertext out streams
module rc4_stream_ctrl #(
  parameter int KEY_SIZE   = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_we,
  input  logic [2:0]  key_addr,
  input  logic [7:0]  key_data,
  input  logic        start,
  output logic        busy,
  output logic        ks_ready,
  output logic        err,
  output logic [31:0] byte_cnt,
  output logic        core_rst,
  output logic        core_ce,
  output logic [7:0]  core_key,
  input  logic        core_ready,
  input  logic [7:0]  core_k,
  rc4_stream_ctrl_if.slave strm
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CRYPTO = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SIZE - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       key_buf [8];
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             can_accept;
  logic             accept;

  // Key buffer has no reset; the host rewrites it before use. Writes are
  // blocked while the core is sampling it so a load sees a consistent key.
  always_ff @(posedge clk) begin
    if (key_we && state != S_LOAD) begin
      key_buf[key_addr] <= key_data;
    end
  end

  // Sequencer. start wins over everything so a rekey can abort any phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (start) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RST_LAST) begin
            state <= S_LOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (cnt == KEY_LAST) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (core_ready) begin
            state <= S_CRYPTO;
          end else if (cnt == TO_LAST) begin
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // in_ready looks only at the output register, never at in_valid, so the
  // handshake has no combinational loop through the upstream source.
  assign can_accept = (state == S_CRYPTO) && (!out_valid_q || strm.out_ready);
  assign accept     = can_accept && strm.in_valid;

  // Output register: a byte is held until the sink takes it; start drops
  // any pending byte because it belongs to the old keystream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      byte_cnt    <= 32'd0;
    end else if (start) begin
      out_valid_q <= 1'b0;
      byte_cnt    <= 32'd0;
    end else if (accept) begin
      out_data_q  <= strm.in_data ^ core_k;
      out_valid_q <= 1'b1;
      byte_cnt    <= byte_cnt + 32'd1;
    end else if (strm.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Core control is decoded from state so an async rst forces core_rst at
  // once. In WAIT the enable drops as soon as core_ready is seen, so the
  // first keystream byte is held for the first accepted input.
  always_comb begin
    core_rst = 1'b1;
    core_ce  = 1'b0;
    core_key = 8'h00;
    busy     = 1'b0;
    ks_ready = 1'b0;
    err      = 1'b0;
    case (state)
      S_RESET: begin
        busy = 1'b1;
      end
      S_LOAD: begin
        busy     = 1'b1;
        core_rst = 1'b0;
        core_ce  = 1'b1;
        core_key = key_buf[cnt[2:0]];
      end
      S_WAIT: begin
        busy     = 1'b1;
        core_rst = 1'b0;
        core_ce  = !core_ready;
      end
      S_CRYPTO: begin
        ks_ready = 1'b1;
        core_rst = 1'b0;
        core_ce  = accept;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign strm.in_ready  = can_accept;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// tb_rc4_stream_ctrl
// Self-checking bench for rc4_stream_ctrl. A behavioural rc4 core model
// collects the key bytes the controller presents, waits CORE_LAT enabled
// cycles, then serves keystream bytes one per enabled edge. Expected
// ciphertext comes from an independent rc4 computation over the key the
// bench wrote, indexed by the count of accepted bytes since start.
module tb_rc4_stream_ctrl;

  localparam int RST_CYCLES = 2;
  localparam int KEY_SIZE   = 8;
  localparam int TIMEOUT    = 4095;
  localparam int CORE_LAT   = 2300;
  localparam int DROP       = 1536;
  localparam int KS_LEN     = 1200;
  localparam int LOAD_CYC   = RST_CYCLES + KEY_SIZE + CORE_LAT + 1;
  localparam int ERR_CYC    = RST_CYCLES + KEY_SIZE + TIMEOUT + 1;

  typedef logic [7:0] key_t [8];
  typedef logic [7:0] ks_t [KS_LEN];

  logic        clk = 1'b0;
  logic        rst;
  logic        key_we;
  logic [2:0]  key_addr;
  logic [7:0]  key_data;
  logic        start;
  logic        busy;
  logic        ks_ready;
  logic        err;
  logic [31:0] byte_cnt;
  logic        core_rst;
  logic        core_ce;
  logic [7:0]  core_key;
  logic        core_ready = 1'b0;
  logic [7:0]  core_k = 8'h00;

  rc4_stream_ctrl_if strm_if ();

  rc4_stream_ctrl #(
    .KEY_SIZE(KEY_SIZE), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
    .start(start), .busy(busy), .ks_ready(ks_ready), .err(err),
    .byte_cnt(byte_cnt), .core_rst(core_rst), .core_ce(core_ce),
    .core_key(core_key), .core_ready(core_ready), .core_k(core_k),
    .strm(strm_if)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  key_t ref_key;
  ks_t  ref_ks;
  int   ks_pos = 0;
  bit   stuck = 1'b0;
  int   ce_cnt = 0;

  // Plain rc4: KSA, drop DROP bytes, keep the next KS_LEN.
  function automatic void rc4_fill(input key_t k, output ks_t ks);
    int s [256];
    int i, j, t;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(k[x % 8])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int x = 0; x < DROP + KS_LEN; x++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (x >= DROP) ks[x - DROP] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  // Core model
  key_t core_mk;
  ks_t  core_ks;
  int   nk = 0;
  int   wait_ce = 0;
  int   idx = 0;
  bit   rdy_m = 1'b0;

  always @(posedge clk) begin
    if (core_rst) begin
      nk <= 0; wait_ce <= 0; idx <= 0; rdy_m <= 1'b0;
      core_ready <= 1'b0; core_k <= 8'h00;
    end else if (core_ce) begin
      if (nk < 8) begin
        core_mk[nk] <= core_key;
        nk <= nk + 1;
      end else if (!rdy_m) begin
        if (wait_ce == 0) rc4_fill(core_mk, core_ks);
        wait_ce <= wait_ce + 1;
        if (wait_ce + 1 >= CORE_LAT && !stuck) begin
          rdy_m <= 1'b1; idx <= 0;
          core_ready <= 1'b1; core_k <= core_ks[0];
        end
      end else begin
        idx <= idx + 1;
        core_k <= (idx + 1 < KS_LEN) ? core_ks[idx + 1] : 8'h00;
      end
    end
  end

  always @(posedge clk) begin
    if (ks_ready && core_ce) ce_cnt <= ce_cnt + 1;
  end

  task automatic write_key(input logic [2:0] a, input logic [7:0] d);
    key_we = 1'b1; key_addr = a; key_data = d; ref_key[a] = d;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    rc4_fill(ref_key, ref_ks);
    ks_pos = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ks_ready(output int ncyc);
    int rdy_seen;
    rdy_seen = 0;
    ncyc = 0;
    while (!ks_ready && ncyc < 10000) begin
      if (busy) ncyc++;
      if (strm_if.in_ready) rdy_seen++;
      @(negedge clk);
    end
    n_vec++;
    if (ks_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ks_ready_wait: ks_ready=%0b after %0d busy cycles, expected 1", ks_ready, ncyc);
    end
    n_vec++;
    if (rdy_seen != 0) begin
      n_err++;
      $display("[TB] FAIL in_ready_while_busy: %0d cycles with in_ready, expected 0", rdy_seen);
    end
  endtask

  task automatic test_reset(input string tag);
    n_vec++;
    if ({busy, ks_ready, err, strm_if.out_valid, core_rst, core_ce, strm_if.in_ready} !== 7'b0000100) begin
      n_err++;
      $display("[TB] FAIL %s_flags: got %b, expected 0000100", tag,
               {busy, ks_ready, err, strm_if.out_valid, core_rst, core_ce, strm_if.in_ready});
    end
    n_vec++;
    if (strm_if.out_data !== 8'h00) begin
      n_err++; $display("[TB] FAIL %s_out_data: got %h, expected 00", tag, strm_if.out_data);
    end
    n_vec++;
    if (byte_cnt !== 32'd0) begin
      n_err++; $display("[TB] FAIL %s_byte_cnt: got %0d, expected 0", tag, byte_cnt);
    end
    n_vec++;
    if (core_key !== 8'h00) begin
      n_err++; $display("[TB] FAIL %s_core_key: got %h, expected 00", tag, core_key);
    end
  endtask

  task automatic test_load();
    int n;
    for (int i = 0; i < 8; i++) write_key(3'(i), 8'(i + 1));
    do_start();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("[TB] FAIL busy_after_start: got %b, expected 1", busy);
    end
    wait_ks_ready(n);
    n_vec++;
    if (n != LOAD_CYC) begin
      n_err++; $display("[TB] FAIL busy_cycles: got %0d, expected %0d", n, LOAD_CYC);
    end
    n_vec++;
    if ({busy, core_ready, byte_cnt} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++; $display("[TB] FAIL crypto_entry: got busy=%b core_ready=%b byte_cnt=%0d, expected 0 1 0",
                        busy, core_ready, byte_cnt);
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rand_data);
    logic [7:0] d_q [$];
    int ce0, base;
    ce0 = ce_cnt;
    base = ks_pos;
    strm_if.out_ready = 1'b1;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        n_vec++;
        if (strm_if.out_valid !== 1'b1 || strm_if.out_data !== (d_q[c-1] ^ ref_ks[base+c-1])) begin
          n_err++;
          $display("[TB] FAIL b2b_byte%0d: got v=%b d=%h, expected v=1 d=%h", c - 1,
                   strm_if.out_valid, strm_if.out_data, d_q[c-1] ^ ref_ks[base+c-1]);
        end
      end
      if (c < n) begin
        strm_if.in_valid = 1'b1;
        strm_if.in_data  = rand_data ? 8'($urandom) : 8'h00;
        d_q.push_back(strm_if.in_data);
      end else begin
        strm_if.in_valid = 1'b0;
      end
      #1;
      if (c < n) begin
        n_vec++;
        if (strm_if.in_ready !== 1'b1) begin
          n_err++; $display("[TB] FAIL b2b_in_ready%0d: got %b, expected 1", c, strm_if.in_ready);
        end
      end
      @(negedge clk);
    end
    ks_pos += n;
    n_vec++;
    if (byte_cnt !== 32'(ks_pos)) begin
      n_err++; $display("[TB] FAIL b2b_byte_cnt: got %0d, expected %0d", byte_cnt, ks_pos);
    end
    n_vec++;
    if (ce_cnt - ce0 != n) begin
      n_err++; $display("[TB] FAIL b2b_ce_pulses: got %0d, expected %0d", ce_cnt - ce0, n);
    end
  endtask

  task automatic test_backpressure(input int n);
    logic [7:0] exp_q [$];
    logic [7:0] held_d, e;
    bit held;
    int sent, rcvd, cyc, ce0;
    sent = 0; rcvd = 0; cyc = 0; held = 1'b0; held_d = 8'h00; ce0 = ce_cnt;
    while ((sent < n || rcvd < n) && cyc < 20000) begin
      if (held) begin
        n_vec++;
        if (strm_if.out_valid !== 1'b1 || strm_if.out_data !== held_d) begin
          n_err++; $display("[TB] FAIL hold_stable: got v=%b d=%h, expected v=1 d=%h",
                            strm_if.out_valid, strm_if.out_data, held_d);
        end
      end
      strm_if.out_ready = 1'($urandom_range(0, 1));
      strm_if.in_valid  = (sent < n) && ($urandom_range(0, 99) < 70);
      strm_if.in_data   = 8'($urandom);
      #1;
      n_vec++;
      if (strm_if.in_ready !== (!strm_if.out_valid || strm_if.out_ready)) begin
        n_err++; $display("[TB] FAIL in_ready_rule: got %b, expected %b", strm_if.in_ready,
                          !strm_if.out_valid || strm_if.out_ready);
      end
      if (strm_if.out_valid && strm_if.out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL bp_extra_byte: got %h, expected no byte", strm_if.out_data);
        end else begin
          e = exp_q.pop_front();
          if (strm_if.out_data !== e) begin
            n_err++; $display("[TB] FAIL bp_byte%0d: got %h, expected %h", rcvd, strm_if.out_data, e);
          end
        end
        rcvd++;
      end
      held = strm_if.out_valid && !strm_if.out_ready;
      held_d = strm_if.out_data;
      if (strm_if.in_valid && strm_if.in_ready) begin
        exp_q.push_back(strm_if.in_data ^ ref_ks[ks_pos]);
        ks_pos++;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    strm_if.in_valid = 1'b0;
    strm_if.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rcvd != n) begin
      n_err++; $display("[TB] FAIL bp_received: got %0d, expected %0d", rcvd, n);
    end
    n_vec++;
    if (byte_cnt !== 32'(ks_pos)) begin
      n_err++; $display("[TB] FAIL bp_byte_cnt: got %0d, expected %0d", byte_cnt, ks_pos);
    end
    n_vec++;
    if (ce_cnt - ce0 != sent) begin
      n_err++; $display("[TB] FAIL bp_ce_pulses: got %0d, expected %0d", ce_cnt - ce0, sent);
    end
  endtask

  task automatic test_rekey();
    int n;
    test_back_to_back(10, 1'b1);
    strm_if.in_valid = 1'b1; strm_if.in_data = 8'h5A; strm_if.out_ready = 1'b0;
    @(negedge clk);
    strm_if.in_valid = 1'b0;
    ks_pos++;
    n_vec++;
    if (strm_if.out_valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL rekey_pending: got %b, expected 1", strm_if.out_valid);
    end
    for (int i = 0; i < 7; i++) write_key(3'(i), 8'hFF);
    key_we = 1'b1; key_addr = 3'd7; key_data = 8'hFF; ref_key[7] = 8'hFF;
    do_start();
    key_we = 1'b0;
    n_vec++;
    if ({strm_if.out_valid, busy, byte_cnt} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++; $display("[TB] FAIL rekey_clear: got v=%b busy=%b cnt=%0d, expected 0 1 0",
                        strm_if.out_valid, busy, byte_cnt);
    end
    strm_if.out_ready = 1'b1;
    wait_ks_ready(n);
    test_back_to_back(16, 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    stuck = 1'b1;
    do_start();
    n = 0;
    while (!err && n < 6000) begin
      if (busy) n++;
      @(negedge clk);
    end
    n_vec++;
    if (err !== 1'b1 || n != ERR_CYC) begin
      n_err++; $display("[TB] FAIL timeout_err: got err=%b after %0d cycles, expected 1 after %0d", err, n, ERR_CYC);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({err, core_rst, busy, strm_if.in_ready} !== 4'b1100) begin
      n_err++; $display("[TB] FAIL error_state: got %b, expected 1100", {err, core_rst, busy, strm_if.in_ready});
    end
    stuck = 1'b0;
    do_start();
    n_vec++;
    if ({err, busy} !== 2'b01) begin
      n_err++; $display("[TB] FAIL error_exit: got err=%b busy=%b, expected 0 1", err, busy);
    end
    wait_ks_ready(n);
    test_back_to_back(8, 1'b1);
  endtask

  task automatic test_async_reset();
    int n;
    do_start();
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_vec++;
    if (core_ce !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("[TB] FAIL load_reached: got ce=%b busy=%b, expected 1 1", core_ce, busy);
    end
    #2 rst = 1'b1;
    #1 test_reset("rst_load");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    wait_ks_ready(n);
    test_back_to_back(4, 1'b1);
    strm_if.in_valid = 1'b1; strm_if.in_data = 8'hC3; strm_if.out_ready = 1'b0;
    @(negedge clk);
    strm_if.in_valid = 1'b0;
    n_vec++;
    if (strm_if.out_valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL rst_crypto_pending: got %b, expected 1", strm_if.out_valid);
    end
    #2 rst = 1'b1;
    #1 test_reset("rst_crypto");
    @(negedge clk);
    rst = 1'b0;
    strm_if.out_ready = 1'b1;
    @(negedge clk);
    do_start();
    wait_ks_ready(n);
    test_back_to_back(8, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key_we = 1'b0; key_addr = 3'd0; key_data = 8'h00; start = 1'b0;
    strm_if.in_valid = 1'b0; strm_if.in_data = 8'h00; strm_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset("por");
    rst = 1'b0;
    @(negedge clk);
    test_load();
    test_back_to_back(64, 1'b0);
    test_backpressure(1000);
    test_rekey();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rc4_stream_ctrl.md
Name: rc4_stream_ctrl

Overview:
- Sequencer and stream front-end for the rc4 keystream core.
- Owns the core's reset and a clock-enable, which integration feeds into an ICG on the core clock.
- Loads an 8-byte key from a host-written key buffer and waits out key scheduling plus the 1536-byte discard.
- Then XORs a valid/ready byte stream with the keystream, advancing the core exactly one byte per accepted input byte.

Parameters:
- KEY_SIZE, 8: key bytes per load. Must equal the core's key length.
- RST_CYCLES, 2: cycles core_rst is held high at the start of each key load (min 1).
- TIMEOUT, 4095: max WAIT cycles for core_ready before ERROR. Must exceed 2320.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_we  in  1  key buffer write strobe
- key_addr  in  3  key buffer byte index
- key_data  in  8  key buffer write data
- start  in  1  one-cycle pulse: (re)key the core
- busy  out  1  high in RESET/LOAD/WAIT
- ks_ready  out  1  high in CRYPTO
- err  out  1  high in ERROR (timeout)
- byte_cnt  out  32  bytes accepted since last start; wraps
- core_rst  out  1  to core rst
- core_ce  out  1  to core clock gate; the core advances on each clk edge where core_ce=1
- core_key  out  8  to core password_input
- core_ready  in  1  from core output_ready
- core_k  in  8  from core K
- in_valid / in_ready / in_data  in/out/in  1/1/8  plaintext stream
- out_valid / out_ready / out_data  out/in/out  1/1/8  ciphertext stream

Behaviour:
- Reset values: state=IDLE, core_rst=1, core_ce=0, core_key=0, busy=0, ks_ready=0, err=0, out_valid=0, out_data=0, byte_cnt=0. The key buffer is not reset.
- Key buffer: 8x8 registers. A write occurs when key_we=1 and state!=LOAD. Writes during LOAD are ignored. A write lands at the clock edge and is visible to the next LOAD.
- State IDLE:
  - core_rst=1, core_ce=0.
  - start -> RESET, with cnt=0 and byte_cnt=0.
- State RESET:
  - core_rst=1, core_ce=0, held RST_CYCLES cycles.
  - Then -> LOAD with cnt=0, and core_rst goes 0 at that same edge.
- State LOAD:
  - core_rst=0, core_ce=1, core_key=key[cnt].
  - After KEY_SIZE cycles -> WAIT, cnt=0.
  - The core samples key[0..7] on consecutive edges.
- State WAIT:
  - core_ce=1, core_key=0, cnt increments each cycle.
  - core_ready=1 -> CRYPTO; core_ce is 0 from that cycle on.
  - cnt==TIMEOUT with core_ready=0 -> ERROR.
- State CRYPTO:
  - in_ready = (!out_valid || out_ready). Combinational; no dependency on in_valid.
  - accept = in_valid & in_ready.
  - core_ce = accept, combinational, so the core advances at the accepting edge.
  - On accept: out_data <= in_data ^ core_k, out_valid <= 1, byte_cnt += 1.
  - Else if out_ready: out_valid <= 0.
  - Throughput is 1 byte/cycle; latency is 1 cycle in to out.
- State ERROR:
  - core_rst=1, err=1, in_ready=0.
  - Only start leaves (-> RESET, err cleared).
- in_ready=0 in every state except CRYPTO.
- The out_valid/out_data hold rule applies in all states except where start clears them. A held output stays stable until out_ready.
- start in any non-IDLE state: -> RESET immediately, with cnt=0, byte_cnt=0, out_valid=0 (pending byte dropped) and err=0. The core is re-keyed from the current buffer.
- start and key_we in the same cycle: the write lands first and is used by the load.
- The keystream never skips or repeats. The nth accepted byte after a start is XORed with keystream byte n, counted from the first post-discard byte.
- Async rst mid-operation: everything returns to reset values, and core_rst asserts immediately.

Test Plan:
- Key 01..08 via key_we, start, then hold in_valid=0 -> busy for 2+8+W cycles; ks_ready rises when core_ready rises; no in_ready before then.
- In CRYPTO, stream 64 bytes of 0x00 with out_ready=1 -> out_data equals the model RC4 keystream after a 1536 drop; byte_cnt=64; back-to-back, one byte/cycle.
- Random out_ready (50%) and in_valid gaps over 1000 bytes -> out_valid/out_data held stable while stalled; core_ce pulses equal accepted bytes; ciphertext matches model.
- Mid-stream (byte 10): write key 0xFF x8, pulse start -> out_valid clears, byte_cnt=0; subsequent output matches the model keystream for the new key from byte 0.
- Tie core_ready=0 -> err=1 after TIMEOUT WAIT cycles, core_rst=1; start -> err=0, reloads normally.
- Assert rst during LOAD and during CRYPTO with out_valid=1 -> all outputs at reset values same cycle; next start completes normally.
